rgb_compare_seq: RTL
====================

# rgb_compare_seq

Parametrised, sequential successor to the 2-bit combinational RGB comparator. It compares two WIDTH-bit operands, unsigned or signed, bit-serially MSB-first, and registers the greater/equal/less result. It then drives the matching LED (red = a>b, green = a==b, blue = a<b) with PWM dimming for a programmable hold window. It sits between the board switch/register inputs and the RGB LED pins.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- PWM_BITS, 4, PWM counter/duty width (≥1)
- HOLD_CYCLES, 16, length of the DISPLAY window in cycles (0 allowed)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a  in  WIDTH  operand A, sampled on the accepted start
- b  in  WIDTH  operand B, sampled on the accepted start
- duty  in  PWM_BITS  LED on-count per PWM period, sampled on the accepted start
- start  in  1  request a compare; accepted only when busy=0
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the result flags update
- gt, eq, lt  out  1 each  registered result flags, one-hot after the first compare
- red, green, blue  out  1 each  PWM LED drives

## Operation
- There are 3 states: IDLE, COMPARE and DISPLAY.
- **Reset:** any rst_n=0, including mid-operation, forces the following immediately:
  - state IDLE
  - all outputs 0, including gt/eq/lt
  - shift registers, counters and latched duty cleared
- **IDLE:**
  - start=1 at an edge latches a, b and duty and enters COMPARE.
  - For SIGNED=1, the MSB of both operands is inverted at capture (offset binary), so the unsigned serial compare gives the signed result.
- **COMPARE:** runs for exactly WIDTH cycles, MSB first, one bit per edge. There is no early exit, so latency is fixed.
  - An internal decided flag and winner are held.
  - The first differing bit sets decided and records the winner: A bit 1 → gt, else lt.
  - Later bits are ignored once decided.
- **End of COMPARE:** on the WIDTH-th COMPARE edge:
  - gt/eq/lt load the result: eq when no bit differed.
  - done=1 for the following cycle.
  - The next state is DISPLAY, or IDLE if HOLD_CYCLES=0.
- **DISPLAY:**
  - The PWM counter is PWM_BITS wide. It resets to 0 on entry, increments each cycle and wraps at 2^PWM_BITS.
  - The selected LED is driven with `pwm_cnt < duty_latched`. The other two LEDs are 0.
  - Mapping: red←gt, green←eq, blue←lt.
  - After HOLD_CYCLES cycles the block returns to IDLE.
- **After DISPLAY:**
  - LEDs return to 0.
  - gt/eq/lt keep their value until the next done.
- **Boundaries:**
  - start while busy=1 is ignored, including on the last DISPLAY cycle.
  - start held high re-triggers on the first IDLE cycle.
  - duty=0 keeps the LED dark for the whole window.
  - duty=2^PWM_BITS−1 gives an on-time of (2^PWM_BITS−1)/2^PWM_BITS.
  - The hold counter is $clog2(HOLD_CYCLES+1) bits and must not overflow.
  - WIDTH=1 is legal: COMPARE lasts one cycle.

## Timing
- Edge E0 with start=1 and IDLE: capture. busy=1 from the cycle after E0.
- Bits are processed on edges E1…E_WIDTH.
- gt/eq/lt and done are valid in the cycle after E_WIDTH, i.e. WIDTH cycles after capture.
- DISPLAY occupies the cycles after E_WIDTH up to edge E_(WIDTH+HOLD_CYCLES).
- busy stays high for WIDTH+HOLD_CYCLES cycles, then falls.
- The LED pattern in DISPLAY is on for the first duty cycles of each 2^PWM_BITS period. It starts on the first DISPLAY cycle.
- All outputs are registered; there is no combinational path from the inputs.
- Asynchronous reset deasserts on a clean clk edge. The first start is accepted at the first edge with rst_n=1.

## Test plan
1. **Unsigned greater-than.**
   - Stimulus: defaults, a=8'h5A, b=8'h3C, duty=4'hF, one start pulse.
   - Response: busy=1 the next cycle; done pulse 8 cycles after capture; gt=1, eq=0, lt=0.
   - LEDs: red high 15 of each 16 cycles for 16 cycles; green and blue 0.
   - busy falls 24 cycles after capture.
2. **Equality.**
   - Stimulus: a=b=8'hA5, duty=4'h8.
   - Response: eq=1; green high 8/16 cycles; red and blue 0; gt=lt=0.
3. **Signed versus unsigned.**
   - Stimulus: a=8'h80, b=8'h01 on a SIGNED=1 instance and on a SIGNED=0 instance.
   - Response: SIGNED=1 gives lt=1 and blue active; SIGNED=0 gives gt=1 and red active.
4. **Duty limits and zero hold.**
   - Stimulus: duty=0; then a HOLD_CYCLES=0 instance.
   - Response with duty=0: flags correct, all LEDs 0 throughout.
   - Response with HOLD_CYCLES=0: busy lasts 8 cycles, done pulses, LEDs never rise.
5. **Ignored start and mid-operation reset.**
   - Stimulus: new start with different operands 3 cycles into COMPARE; then rst_n=0 during DISPLAY.
   - Response to the extra start: ignored; the result matches the original operands.
   - Response to reset: all outputs 0 immediately, without waiting for clk; the next start completes normally.
6. **Exhaustive 2-bit check.**
   - Stimulus: WIDTH=2, HOLD_CYCLES=4 instance; all 16 (a,b) pairs, each run to completion.
   - Response: exactly one of gt/eq/lt per pair, matching the arithmetic compare; LED colour matches the flag.

Source files
------------

// File: rtl/rgb_compare_seq.sv
// Bit-serial MSB-first magnitude comparator (unsigned or signed) that registers
// gt/eq/lt and shows the result on a PWM-dimmed RGB LED for a hold window.
module rgb_compare_seq #(
  parameter int WIDTH       = 8,
  parameter int SIGNED      = 0,
  parameter int PWM_BITS    = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                gt,
  output logic                eq,
  output logic                lt,
  output logic                red,
  output logic                green,
  output logic                blue
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  // Inverting the sign bit maps two's complement onto offset binary.
  localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  typedef enum logic [1:0] {IDLE, COMPARE, DISPLAY} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, pwm_q, pwm_d, pwm_nxt;
  logic [CW-1:0]       bit_q, bit_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                decided_q, decided_d, win_q, win_d;
  logic                gt_q, gt_d, eq_q, eq_d, lt_q, lt_d, done_q, done_d;
  logic                red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                dec_now, win_now, pwm_on;

  assign dec_now = decided_q | (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign win_now = decided_q ? win_q : a_q[WIDTH-1];
  assign pwm_nxt = pwm_q + PWM_BITS'(1);
  assign pwm_on  = (pwm_nxt < duty_q);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    duty_d    = duty_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    pwm_d     = pwm_q;
    decided_d = decided_q;
    win_d     = win_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    done_d    = 1'b0;
    red_d     = 1'b0;
    green_d   = 1'b0;
    blue_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a ^ FLIP;
          b_d       = b ^ FLIP;
          duty_d    = duty;
          bit_d     = '0;
          decided_d = 1'b0;
          win_d     = 1'b0;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        a_d       = a_q << 1;
        b_d       = b_q << 1;
        decided_d = dec_now;
        win_d     = win_now;
        bit_d     = bit_q + CW'(1);
        if (bit_q == LAST_BIT) begin
          gt_d   = dec_now & win_now;
          eq_d   = ~dec_now;
          lt_d   = dec_now & ~win_now;
          done_d = 1'b1;
          pwm_d  = '0;
          hold_d = '0;
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            // LEDs are registered, so the first DISPLAY cycle (pwm=0) is decided here.
            state_d = DISPLAY;
            red_d   = dec_now & win_now & (duty_q != '0);
            green_d = ~dec_now & (duty_q != '0);
            blue_d  = dec_now & ~win_now & (duty_q != '0);
          end
        end
      end
      DISPLAY: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d  = hold_q + HW'(1);
          pwm_d   = pwm_nxt;
          red_d   = gt_q & pwm_on;
          green_d = eq_q & pwm_on;
          blue_d  = lt_q & pwm_on;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      duty_q    <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      pwm_q     <= '0;
      decided_q <= 1'b0;
      win_q     <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      done_q    <= 1'b0;
      red_q     <= 1'b0;
      green_q   <= 1'b0;
      blue_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      duty_q    <= duty_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      pwm_q     <= pwm_d;
      decided_q <= decided_d;
      win_q     <= win_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      done_q    <= done_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign gt    = gt_q;
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
